// File: rtl/spi_slave_modes_if.sv
// SPI slave pin and word-handshake bundle.
// slave: SPI pins in, miso out, rx/tx word handshakes and status.
interface spi_slave_modes_if #(
    parameter int BITS = 8
);
    logic            sck;
    logic            mosi;
    logic            ssel;
    logic            miso;
    logic            miso_oe;
    logic [BITS-1:0] rx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic [BITS-1:0] tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            rx_overrun;
    logic            tx_underrun;
    logic            busy;

    modport slave (
        input  sck, mosi, ssel, rx_ready, tx_data, tx_valid,
        output miso, miso_oe, rx_data, rx_valid, tx_ready,
        output rx_overrun, tx_underrun, busy
    );

    modport master (
        output sck, mosi, ssel, rx_ready, tx_data, tx_valid,
        input  miso, miso_oe, rx_data, rx_valid, tx_ready,
        input  rx_overrun, tx_underrun, busy
    );
endinterface

// File: rtl/spi_slave_modes.sv
// SPI slave, all four CPOL/CPHA modes, oversampled by the system clock.
// Ports: clk, rst_n (async, active-low), bus (spi_slave_modes_if.slave).
module spi_slave_modes #(
    parameter int              BITS      = 8,
    parameter int              CPOL      = 0,
    parameter int              CPHA      = 0,
    parameter int              LSB_FIRST = 0,
    parameter logic [BITS-1:0] IDLE_WORD = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_slave_modes_if.slave bus
);
    localparam int   CW  = $clog2(BITS);
    localparam logic POL = (CPOL != 0);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state;
    state_t          state_nx;
    logic [2:0]      sck_p;
    logic [1:0]      mosi_p;
    logic [1:0]      ssel_p;
    logic [CW-1:0]   cnt;
    logic [BITS-1:0] rx_shift;
    logic [BITS-1:0] tx_shift;
    logic [BITS-1:0] hold;
    logic            hold_full;
    logic            done;

    logic sck_s, sck_q, mosi_s, ssel_s;
    logic rise, fall, lead, trail;
    logic run, start, sample_e, shift_e, last, load, accept;

    // sck_p[1] is the synchronised pin, sck_p[2] the edge-detect stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_p  <= {3{POL}};
            mosi_p <= '0;
            ssel_p <= 2'b11;
        end else begin
            sck_p  <= {sck_p[1:0], bus.sck};
            mosi_p <= {mosi_p[0], bus.mosi};
            ssel_p <= {ssel_p[0], bus.ssel};
        end
    end

    assign sck_s  = sck_p[1];
    assign sck_q  = sck_p[2];
    assign mosi_s = mosi_p[1];
    assign ssel_s = ssel_p[1];

    assign rise  = sck_s & ~sck_q;
    assign fall  = ~sck_s & sck_q;
    assign lead  = POL ? fall : rise;
    assign trail = POL ? rise : fall;

    // edges only count while selected; a deselect clk is ignored
    assign run      = (state == ACTIVE) & ~ssel_s;
    assign start    = (state == IDLE) & ~ssel_s;
    assign sample_e = ((CPHA != 0) ? trail : lead) & run;
    assign shift_e  = ((CPHA != 0) ? lead : trail) & run;
    assign last     = (cnt == CW'(BITS - 1));

    // counter at 0 on a shift edge marks a word boundary in both phases
    assign load   = ((CPHA == 0) & start) | (shift_e & (cnt == '0));
    assign accept = bus.tx_valid & ~hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (!ssel_s) state_nx = ACTIVE;
            ACTIVE: if (ssel_s)  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            rx_shift        <= '0;
            done            <= 1'b0;
            bus.rx_data     <= '0;
            bus.rx_valid    <= 1'b0;
            bus.rx_overrun  <= 1'b0;
            bus.tx_underrun <= 1'b0;
            tx_shift        <= '0;
            hold            <= '0;
            hold_full       <= 1'b0;
        end else begin
            done <= sample_e & last;

            if (state == IDLE)  cnt <= '0;
            else if (sample_e)  cnt <= last ? '0 : cnt + CW'(1);

            if (sample_e) begin
                if (LSB_FIRST != 0)
                    rx_shift <= {mosi_s, rx_shift[BITS-1:1]};
                else
                    rx_shift <= {rx_shift[BITS-2:0], mosi_s};
            end

            // completed word lands one clk after its final sample
            bus.rx_overrun <= done & bus.rx_valid & ~bus.rx_ready;
            if (done) begin
                bus.rx_data  <= rx_shift;
                bus.rx_valid <= 1'b1;
            end else if (bus.rx_ready) begin
                bus.rx_valid <= 1'b0;
            end

            bus.tx_underrun <= load & ~hold_full;
            if (load) begin
                tx_shift <= hold_full ? hold : IDLE_WORD;
            end else if (shift_e) begin
                if (LSB_FIRST != 0)
                    tx_shift <= {1'b0, tx_shift[BITS-1:1]};
                else
                    tx_shift <= {tx_shift[BITS-2:0], 1'b0};
            end

            // an accept while an empty slot loads stays queued
            if (load & hold_full) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full <= 1'b1;
                hold      <= bus.tx_data;
            end
        end
    end

    assign bus.miso     = (state == ACTIVE) &
                          ((LSB_FIRST != 0) ? tx_shift[0] : tx_shift[BITS-1]);
    assign bus.miso_oe  = ~ssel_s;
    assign bus.busy     = (state == ACTIVE);
    assign bus.tx_ready = ~hold_full;
endmodule

// File: tb/tb_spi_slave_modes.sv
// Randomised SPI master driving one slave per CPOL/CPHA mode.
// A word-level model predicts rx words, master reads and status pulses.
module tb_spi_slave_modes;
    localparam int HP = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]      sck_v, ssel_v, rxr_v, txv_v;
    logic            mosi;
    logic [3:0][7:0] txd_v, rxd_v;
    logic [3:0]      miso_v, oe_v, rxv_v, txr_v, ovr_v, und_v, busy_v;

    for (genvar g = 0; g < 4; g++) begin : u
        spi_slave_modes_if #(.BITS(8)) ifc ();
        assign ifc.sck      = sck_v[g];
        assign ifc.ssel     = ssel_v[g];
        assign ifc.mosi     = mosi;
        assign ifc.rx_ready = rxr_v[g];
        assign ifc.tx_valid = txv_v[g];
        assign ifc.tx_data  = txd_v[g];
        assign miso_v[g]    = ifc.miso;
        assign oe_v[g]      = ifc.miso_oe;
        assign rxd_v[g]     = ifc.rx_data;
        assign rxv_v[g]     = ifc.rx_valid;
        assign txr_v[g]     = ifc.tx_ready;
        assign ovr_v[g]     = ifc.rx_overrun;
        assign und_v[g]     = ifc.tx_underrun;
        assign busy_v[g]    = ifc.busy;
        spi_slave_modes #(
            .BITS(8), .CPOL(g / 2), .CPHA(g % 2),
            .LSB_FIRST((g != 0) ? 1 : 0), .IDLE_WORD(8'hFF)
        ) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
    end

    int checks = 0;
    int errors = 0;
    int cur = 0;
    logic [7:0] rxq[$];
    logic [7:0] hold_m[4];
    bit         full_m[4];
    int und_exp[4], ovr_exp[4], und_cnt[4], ovr_cnt[4];

    function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, got, exp);
        end
    endfunction

    // word the slave shifts out at a load: queued word, else the idle word
    function automatic logic [7:0] take(int m);
        if (full_m[m]) begin
            full_m[m] = 1'b0;
            return hold_m[m];
        end
        und_exp[m]++;
        return 8'hFF;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int m = 0; m < 4; m++) begin
                if (und_v[m]) und_cnt[m]++;
                if (ovr_v[m]) ovr_cnt[m]++;
                if (rxv_v[m] && rxr_v[m]) begin
                    if (rxq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_spurious inst %0d data %0h", m, rxd_v[m]);
                    end else begin
                        chk("rx_data", rxd_v[m], rxq.pop_front());
                    end
                end
            end
            if (!busy_v[cur]) chk("miso_idle", miso_v[cur], 0);
        end
    end

    task automatic push(int m, logic [7:0] d);
        chk("tx_ready", txr_v[m], !full_m[m]);
        if (!full_m[m]) begin
            txv_v[m] = 1'b1;
            txd_v[m] = d;
            @(posedge clk); #1;
            txv_v[m] = 1'b0;
            full_m[m] = 1'b1;
            hold_m[m] = d;
            chk("tx_ready_full", txr_v[m], 0);
        end
    endtask

    task automatic frame(int m, int nw, int cut, bit rst_mid,
                         logic [7:0] w0, logic [7:0] w1,
                         output logic [7:0] rd0);
        bit pol = (m >= 2);
        bit pha = (m % 2 == 1);
        bit lsb = (m != 0);
        logic [7:0] w, rd, ex;
        int nb, idx;
        rd0 = '0;
        ex = '0;
        cur = m;
        ssel_v[m] = 1'b0;
        if (!pha) ex = take(m);
        repeat (HP) @(posedge clk); #1;
        chk("busy", busy_v[m], 1);
        chk("miso_oe", oe_v[m], 1);
        for (int k = 0; k < nw; k++) begin
            w = (k == 0) ? w0 : (k == 1) ? w1 : 8'($urandom);
            nb = (cut > 0) ? cut : 8;
            if (pha) ex = take(m);
            if (nb == 8) rxq.push_back(w);
            rd = '0;
            for (int b = 0; b < nb; b++) begin
                idx = lsb ? b : 7 - b;
                if (!pha) begin
                    mosi = w[idx];
                    repeat (HP) @(posedge clk); #1;
                    rd[idx] = miso_v[m];
                    sck_v[m] = !pol;
                    repeat (HP) @(posedge clk); #1;
                    sck_v[m] = pol;
                end else begin
                    sck_v[m] = !pol;
                    mosi = w[idx];
                    repeat (HP) @(posedge clk); #1;
                    rd[idx] = miso_v[m];
                    sck_v[m] = pol;
                    repeat (HP) @(posedge clk); #1;
                end
            end
            if (k == 0) rd0 = rd;
            if (nb == 8) begin
                chk("master_read", rd, ex);
                if (!pha) ex = take(m);
            end
        end
        if (rst_mid) begin
            rst_n = 1'b0;
            #1;
            for (int i = 0; i < 4; i++) begin
                chk("rst_busy", busy_v[i], 0);
                chk("rst_rx_valid", rxv_v[i], 0);
                chk("rst_rx_data", rxd_v[i], 0);
                chk("rst_miso", miso_v[i], 0);
                chk("rst_miso_oe", oe_v[i], 0);
                chk("rst_tx_ready", txr_v[i], 1);
                chk("rst_overrun", ovr_v[i], 0);
                chk("rst_underrun", und_v[i], 0);
                full_m[i] = 1'b0;
            end
        end
        repeat (HP) @(posedge clk); #1;
        ssel_v[m] = 1'b1;
        sck_v[m] = pol;
        if (rst_mid) begin
            repeat (3) @(posedge clk); #1;
            rst_n = 1'b1;
        end
        repeat (4 * HP) @(posedge clk); #1;
        chk("busy_after", busy_v[m], 0);
        chk("underruns", und_cnt[m], und_exp[m]);
        if (rxr_v[m]) chk("rx_pending", rxq.size(), 0);
    endtask

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog cycle budget expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd, a, b;
        int m, cut, nw, u0;
        sck_v  = 4'b1100;
        ssel_v = 4'hF;
        rxr_v  = 4'hF;
        txv_v  = '0;
        txd_v  = '0;
        mosi   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            full_m[i] = 0; hold_m[i] = 0;
            und_exp[i] = 0; ovr_exp[i] = 0;
            und_cnt[i] = 0; ovr_cnt[i] = 0;
        end
        repeat (3) @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_busy", busy_v[i], 0);
            chk("reset_tx_ready", txr_v[i], 1);
            chk("reset_rx_valid", rxv_v[i], 0);
            chk("reset_rx_data", rxd_v[i], 0);
            chk("reset_miso", miso_v[i], 0);
            chk("reset_miso_oe", oe_v[i], 0);
        end
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;

        // mode 0: A5 queued, 3C received, held until rx_ready
        push(0, 8'hA5);
        rxr_v[0] = 1'b0;
        frame(0, 1, 0, 0, 8'h3C, 8'h00, rd);
        chk("m0_master_read", rd, 8'hA5);
        chk("m0_rx_valid", rxv_v[0], 1);
        chk("m0_rx_data", rxd_v[0], 8'h3C);
        repeat (5) @(posedge clk); #1;
        chk("m0_rx_hold", rxv_v[0], 1);
        rxr_v[0] = 1'b1;
        @(posedge clk); #1;
        chk("m0_rx_clear", rxv_v[0], 0);
        chk("m0_rx_drained", rxq.size(), 0);
        chk("m0_underrun", und_cnt[0], 1);

        // modes 1..3, LSB first: 0x01 both directions
        for (int i = 1; i < 4; i++) begin
            push(i, 8'h01);
            frame(i, 1, 0, 0, 8'h01, 8'h00, rd);
            chk("lsb_master_read", rd, 8'h01);
            chk("lsb_rx_data", rxd_v[i], 8'h01);
        end

        // two words, rx_ready low: second word wins, one overrun
        rxr_v[3] = 1'b0;
        frame(3, 2, 0, 0, 8'h5A, 8'hC3, rd);
        void'(rxq.pop_front());
        ovr_exp[3]++;
        chk("ovr_rx_data", rxd_v[3], 8'hC3);
        chk("ovr_rx_valid", rxv_v[3], 1);
        chk("ovr_count", ovr_cnt[3], 1);
        rxr_v[3] = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("ovr_drained", rxq.size(), 0);

        // nothing queued: idle word and one underrun per word
        u0 = und_cnt[1];
        frame(1, 2, 0, 0, 8'h96, 8'h69, rd);
        chk("idle_word_read", rd, 8'hFF);
        chk("underrun_per_word", und_cnt[1] - u0, 2);

        // deselect after 5 bits, then a clean frame
        frame(2, 1, 5, 0, 8'hE7, 8'h00, rd);
        chk("abort_no_valid", rxv_v[2], 0);
        push(2, 8'h4B);
        frame(2, 1, 0, 0, 8'h2D, 8'h00, rd);
        chk("after_abort_rx", rxd_v[2], 8'h2D);
        chk("after_abort_read", rd, 8'h4B);

        // reset mid-word, queued word elsewhere is dropped too
        push(2, 8'h77);
        frame(0, 1, 5, 1, 8'hB1, 8'h00, rd);
        chk("after_reset_tx_ready", txr_v[2], 1);
        frame(0, 1, 0, 0, 8'h9E, 8'h00, rd);
        chk("after_reset_rx", rxd_v[0], 8'h9E);

        for (int it = 0; it < 30; it++) begin
            m = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) push(m, 8'($urandom));
            cut = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
            nw = (cut > 0) ? 1 : $urandom_range(1, 3);
            a = 8'($urandom);
            b = 8'($urandom);
            frame(m, nw, cut, 0, a, b, rd);
            chk("rnd_overruns", ovr_cnt[m], ovr_exp[m]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_modes.md
SPI_SLAVE_MODES -- requirements
Module: spi_slave_modes

Interface
REQ-001 The block SHALL have parameter BITS, default 8: word width, legal range 4..32.
REQ-002 The block SHALL have parameter CPOL, default 0: idle level of sck.
REQ-003 The block SHALL have parameter CPHA, default 0: 0 = sample on the leading edge, 1 = sample on the trailing edge.
REQ-004 The block SHALL have parameter LSB_FIRST, default 0: 1 = bit 0 is shifted first on both mosi and miso.
REQ-005 The block SHALL have parameter IDLE_WORD, default all-ones: word transmitted when no tx data is queued.
REQ-006 The block SHALL have port clk, input, 1 bit: the single system clock; all logic SHALL run on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have ports sck, mosi and ssel, each input, 1 bit, asynchronous: SPI pins; ssel is active-low.
REQ-009 The block SHALL have port miso, output, 1 bit: serial data out.
REQ-010 The block SHALL have port miso_oe, output, 1 bit: high while the synchronised ssel is active.
REQ-011 The block SHALL have ports rx_data (output, BITS), rx_valid (output, 1) and rx_ready (input, 1): received-word handshake.
REQ-012 The block SHALL have ports tx_data (input, BITS), tx_valid (input, 1) and tx_ready (output, 1): transmit holding-register handshake.
REQ-013 The block SHALL have ports rx_overrun, tx_underrun and busy, each output, 1 bit: status.

Function
REQ-014 sck, mosi and ssel SHALL each pass through a 2-flop synchroniser; edge detection SHALL use one further register stage; clk SHALL be at least 4x the sck frequency.
REQ-015 The leading edge SHALL be rising when CPOL=0 and falling when CPOL=1; the sample edge SHALL be the leading edge when CPHA=0, else the trailing edge; the shift edge SHALL be the other edge.
REQ-016 The state machine SHALL have states IDLE and ACTIVE: IDLE->ACTIVE on synchronised ssel low; ACTIVE->IDLE on synchronised ssel high; busy SHALL equal (state==ACTIVE).
REQ-017 The bit counter SHALL count sample edges modulo BITS, SHALL be cleared in IDLE, and SHALL wrap to 0 on the final bit of each word.
REQ-018 On each sample edge, synchronised mosi SHALL shift into the rx shift register: at the LSB end when LSB_FIRST=0, at the MSB end when LSB_FIRST=1.
REQ-019 On the final sample edge of a word, the completed word SHALL be written to rx_data and rx_valid SHALL be set on the next clk.
REQ-020 rx_valid SHALL hold until a clk with rx_ready high, and SHALL clear in that clk unless a new word completes in the same clk.
REQ-021 If a word completes while rx_valid is still high and rx_ready is low, rx_data SHALL be overwritten with the new word, rx_valid SHALL remain high, and rx_overrun SHALL pulse for one clk.
REQ-022 The tx holding register SHALL be one word deep; tx_ready SHALL be high when it is empty; a transfer SHALL occur when tx_valid and tx_ready are high.
REQ-023 At a word load the tx shift register SHALL take the holding register and mark it empty; if the holding register is empty, it SHALL take IDLE_WORD and tx_underrun SHALL pulse for one clk.
REQ-024 Word load timing SHALL depend on CPHA.
- CPHA=0: the word SHALL load in the IDLE->ACTIVE clk and at the first shift edge after a word's final sample.
- CPHA=1: the word SHALL load at the shift edge where the bit counter is 0.
REQ-025 Every other shift edge SHALL advance the tx shift register by one bit.
REQ-026 miso SHALL equal the tx shift register MSB (LSB when LSB_FIRST=1) while ACTIVE, and SHALL be 0 while IDLE.
REQ-027 If ssel deasserts mid-word, the partial rx word SHALL be discarded with no rx_valid, the bit counter SHALL clear, and a tx word already loaded SHALL be lost while the holding register contents are kept.
REQ-028 If an accept on the tx handshake coincides with a word load from an empty holding register, IDLE_WORD SHALL load and the accepted data SHALL remain queued for the next word.
REQ-029 Latency from an sck pin edge to its internal edge event SHALL be 3 clk; from the final sample edge to rx_valid, 4 clk.

Reset
REQ-030 While rst_n is low, all state SHALL clear asynchronously.
- Synchroniser flops SHALL reset to the idle values: sck=CPOL, ssel=1.
- Outputs SHALL reset to: state IDLE, rx_data 0, rx_valid 0, tx holding register empty (tx_ready 1), rx_overrun 0, tx_underrun 0, busy 0, miso 0, miso_oe 0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer without rx_valid; after release the block SHALL wait in IDLE for a fresh ssel falling edge.

Verification
REQ-032 Mode 0, BITS=8: queue tx 0xA5, master sends 0x3C -> master reads 0xA5, rx_data 0x3C, rx_valid until rx_ready.
REQ-033 Each of modes 1, 2 and 3 with LSB_FIRST=1: send 0x01 -> rx_data 0x01, miso bit order LSB first.
REQ-034 Two back-to-back words in one ssel frame with rx_ready held low -> second word in rx_data and one rx_overrun pulse.
REQ-035 No tx queued -> master reads IDLE_WORD (0xFF) and sees one tx_underrun pulse per word.
REQ-036 ssel deasserted after 5 bits -> no rx_valid; the next full frame is received correctly.
REQ-037 rst_n pulsed low mid-word -> all outputs at their reset values immediately; the next frame is received correctly.
